// File: rtl/pio_scan_pkg.sv
// Shared types for the PIO scan sequencer: FSM states, FIFO event record and
// a constant-width helper.
package pio_scan_pkg;

  localparam int EVT_CH_W   = 3;
  localparam int EVT_DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE
  } state_t;

  // Sized for the widest legal configuration; users slice what they need.
  typedef struct packed {
    logic [EVT_CH_W-1:0]   ch;
    logic [EVT_DATA_W-1:0] data;
  } evt_t;

  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/pio_scan_fifo.sv
// Synchronous event FIFO; a push while full is accepted only alongside a pop.
module pio_scan_fifo
  import pio_scan_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_push,
  input  evt_t i_data,
  input  logic i_pop,
  output logic o_full,
  output logic o_valid,
  output evt_t o_head
);

  localparam int PTR_W = clog2(DEPTH);

  evt_t             r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W:0]   r_cnt;
  logic             r_full;
  logic             r_valid;
  logic             w_pop;
  logic             w_push;
  logic [PTR_W:0]   w_cnt_nxt;

  assign w_pop  = i_pop && r_valid;
  assign w_push = i_push && (!r_full || w_pop);

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 1'b1;
      2'b01:   w_cnt_nxt = r_cnt - 1'b1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == (PTR_W+1)'(DEPTH));
      r_valid <= (w_cnt_nxt != '0);
    end
  end

  assign o_full  = r_full;
  assign o_valid = r_valid;
  assign o_head  = r_mem[r_rd];

endmodule

// File: rtl/pio_scan_sequencer.sv
// Time-shares one PIO read path across NUM_CH ports and queues only the
// channels whose captured value differs from the last one reported.
module pio_scan_sequencer
  import pio_scan_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 27,
  parameter int READ_LAT   = 1,
  parameter int SCAN_DIV   = 16,
  parameter int FIFO_DEPTH = 4,
  localparam int CH_W      = clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [CH_W-1:0]   ch_sel,
  output logic [1:0]        address,
  input  logic [31:0]       readdata,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  output logic [DATA_W-1:0] evt_data,
  output logic              overflow,
  input  logic              clear_ovf,
  output logic              busy
);

  localparam int CNT_W = clog2(SCAN_DIV);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t            r_state;
  logic [CH_W-1:0]   r_ch_sel;
  logic [1:0]        r_wait;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_ovf;
  logic [DATA_W-1:0] r_shadow [NUM_CH];
  logic [NUM_CH-1:0] r_seen;

  logic [DATA_W-1:0] w_sample;
  logic              w_change;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_fifo_valid;
  evt_t              w_evt;
  evt_t              w_head;
  logic              w_unused;

  assign w_sample = readdata[DATA_W-1:0];
  assign w_change = (r_state == S_CAPTURE) &&
                    (!r_seen[r_ch_sel] || (w_sample != r_shadow[r_ch_sel]));
  assign w_pop    = w_fifo_valid && evt_ready;
  assign w_push   = w_change && (!w_full || w_pop);

  always_comb begin
    w_evt      = '0;
    w_evt.ch   = EVT_CH_W'(r_ch_sel);
    w_evt.data = EVT_DATA_W'(w_sample);
  end

  pio_scan_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  (w_evt),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_valid (w_fifo_valid),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_ch_sel <= '0;
      r_wait   <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_ovf    <= 1'b0;
      r_seen   <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) r_shadow[i] <= '0;
    end else begin
      // A dropped event outranks a same-cycle clear.
      if (w_change && !w_push) r_ovf <= 1'b1;
      else if (clear_ovf)      r_ovf <= 1'b0;

      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;

      case (r_state)
        S_IDLE: begin
          if (enable && (r_cnt == '0)) begin
            r_state  <= S_ISSUE;
            r_cnt    <= CNT_W'(SCAN_DIV - 1);
            r_ch_sel <= '0;
            r_busy   <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (READ_LAT > 1) begin
            r_state <= S_WAIT;
            r_wait  <= 2'(READ_LAT - 2);
          end else begin
            r_state <= S_CAPTURE;
          end
        end
        S_WAIT: begin
          if (r_wait == '0) r_state <= S_CAPTURE;
          else              r_wait  <= r_wait - 1'b1;
        end
        S_CAPTURE: begin
          // Shadow only advances once the event is safely queued.
          if (w_push) begin
            r_shadow[r_ch_sel] <= w_sample;
            r_seen[r_ch_sel]   <= 1'b1;
          end
          if (r_ch_sel == LAST_CH) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state  <= S_ISSUE;
            r_ch_sel <= r_ch_sel + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ch_sel    = r_ch_sel;
  assign address   = '0;
  assign busy      = r_busy;
  assign overflow  = r_ovf;
  assign evt_valid = w_fifo_valid;
  assign evt_ch    = w_head.ch[CH_W-1:0];
  assign evt_data  = w_head.data[DATA_W-1:0];
  assign w_unused  = ^{readdata, w_head};

endmodule

// File: tb/tb_pio_scan_sequencer.sv
// Bench for pio_scan_sequencer: behavioural PIO mux with one-cycle read
// latency, expected-event queue checked on each accepted event.
module tb_pio_scan_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        evt_ready = 1'b0;
  logic        clear_ovf = 1'b0;
  logic [1:0]  ch_sel;
  logic [1:0]  address;
  logic [31:0] readdata;
  logic        evt_valid;
  logic [1:0]  evt_ch;
  logic [26:0] evt_data;
  logic        overflow;
  logic        busy;

  logic [31:0] ports [4];

  always #5 clk = ~clk;

  always @(posedge clk) readdata <= ports[ch_sel];

  pio_scan_sequencer #(
    .NUM_CH     (4),
    .DATA_W     (27),
    .READ_LAT   (1),
    .SCAN_DIV   (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .ch_sel    (ch_sel),
    .address   (address),
    .readdata  (readdata),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_data  (evt_data),
    .overflow  (overflow),
    .clear_ovf (clear_ovf),
    .busy      (busy)
  );

  typedef struct packed {
    logic [1:0]  ch;
    logic [26:0] data;
  } exp_t;

  typedef struct packed {
    logic [3:0][31:0] p;
    logic [3:0]       mask;
  } vec_t;

  exp_t sb [$];
  exp_t mon_e;
  vec_t vt [5];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t0, t1, t2, l0, l1, l2, n;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each accepted head event is compared with the oldest expectation.
  always begin
    @(negedge clk);
    #1;
    if (evt_valid && evt_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected event: got ch%0d data %0h expected none", evt_ch, evt_data);
      end else begin
        mon_e = sb.pop_front();
        check("evt ch", 32'(evt_ch), 32'(mon_e.ch));
        check("evt data", 32'(evt_data), 32'(mon_e.data));
      end
    end
  end

  task automatic push_exp(input int ch, input logic [31:0] v);
    exp_t e;
    e.ch   = 2'(ch);
    e.data = v[26:0];
    sb.push_back(e);
  endtask

  task automatic set_vec(input int i, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [31:0] a3, input logic [3:0] m);
    vt[i].p[0] = a0;
    vt[i].p[1] = a1;
    vt[i].p[2] = a2;
    vt[i].p[3] = a3;
    vt[i].mask = m;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " ch_sel"},    32'(ch_sel),    0);
    check({tag, " address"},   32'(address),   0);
    check({tag, " evt_valid"}, 32'(evt_valid), 0);
    check({tag, " evt_ch"},    32'(evt_ch),    0);
    check({tag, " evt_data"},  32'(evt_data),  0);
    check({tag, " overflow"},  32'(overflow),  0);
    check({tag, " busy"},      32'(busy),      0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("idle timeout", 32'(busy), 0);
  endtask

  task automatic wait_busy(output int t);
    int k;
    k = 0;
    @(negedge clk);
    while (!busy && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!busy) check("busy timeout", 32'(busy), 1);
    t = cyc;
  endtask

  task automatic count_high(output int len);
    len = 0;
    while (busy && len < 20) begin
      @(negedge clk);
      len++;
    end
  endtask

  task automatic wait_scan(output int t, output int len);
    wait_busy(t);
    count_high(len);
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    check(name, 32'(sb.size()), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_vec(0, 32'h0000123, 32'h0000123, 32'hFFFFFFFF, 32'h0000123, 4'b0100);
    set_vec(1, 32'h0000123, 32'h0000123, 32'h07FFFFFF, 32'h0000123, 4'b0000);
    set_vec(2, 32'h0000001, 32'h0000123, 32'h07FFFFFF, 32'h2AAAAAA, 4'b1001);
    set_vec(3, 32'h5555555, 32'h0000000, 32'h0000000, 32'h7FFFFFF, 4'b1111);
    set_vec(4, 32'hA5555555, 32'h0000000, 32'h0000000, 32'h07FFFFFF, 4'b0000);

    for (int k = 0; k < 4; k++) ports[k] = 32'h0000123;
    enable    = 1'b1;
    evt_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");

    // First scan starts immediately after reset release.
    for (int k = 0; k < 4; k++) push_exp(k, 32'h0000123);
    reset_n = 1'b1;
    @(negedge clk);
    check("first issue busy", 32'(busy), 1);
    count_high(l0);
    check("first busy len", 32'(l0), 8);
    wait_drain("init drain");

    wait_scan(t0, l0);
    wait_scan(t1, l1);
    wait_scan(t2, l2);
    check("interval 1", 32'(t1 - t0), 16);
    check("interval 2", 32'(t2 - t1), 16);
    check("steady busy len", 32'(l2), 8);

    for (int i = 0; i < 5; i++) begin
      wait_idle();
      for (int k = 0; k < 4; k++) begin
        ports[k] = vt[i].p[k];
        if (vt[i].mask[k]) push_exp(k, vt[i].p[k]);
      end
      if (vt[i].mask != 4'b0000) begin
        n = 0;
        while (!evt_valid && n < 25) begin
          @(negedge clk);
          n++;
        end
        check($sformatf("vec%0d latency", i), 32'(evt_valid), 1);
      end
      wait_drain($sformatf("vec%0d drain", i));
      wait_scan(t0, l0);
      wait_scan(t0, l0);
    end

    // Fill the FIFO, then force drops.
    wait_idle();
    evt_ready = 1'b0;
    ports[0] = 32'h11; ports[1] = 32'h22; ports[2] = 32'h33; ports[3] = 32'h44;
    for (int k = 0; k < 4; k++) push_exp(k, ports[k]);
    wait_scan(t0, l0);
    check("ovf pre", 32'(overflow), 0);
    check("ovf fifo valid", 32'(evt_valid), 1);
    ports[0] = 32'h55; ports[1] = 32'h66; ports[2] = 32'h77; ports[3] = 32'h88;
    for (int k = 0; k < 4; k++) push_exp(k, ports[k]);
    wait_scan(t0, l0);
    check("ovf set", 32'(overflow), 1);
    evt_ready = 1'b1;
    wait_drain("ovf retry drain");
    clear_ovf = 1'b1;
    @(negedge clk);
    clear_ovf = 1'b0;
    check("ovf cleared", 32'(overflow), 0);

    // Push into a full FIFO in the same cycle as a pop.
    wait_idle();
    evt_ready = 1'b0;
    ports[0] = 32'h1111; ports[1] = 32'h2222; ports[2] = 32'h3333; ports[3] = 32'h4444;
    for (int k = 0; k < 4; k++) push_exp(k, ports[k]);
    wait_scan(t0, l0);
    check("fullpp valid", 32'(evt_valid), 1);
    ports[0] = 32'h5555;
    push_exp(0, 32'h5555);
    wait_busy(t0);
    @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    count_high(l0);
    check("fullpp ovf", 32'(overflow), 0);
    evt_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("fullpp occupancy", 32'(evt_valid), 0);
    check("fullpp queue", 32'(sb.size()), 0);

    // Drop enable during the ch1 capture.
    wait_idle();
    ports[2] = 32'h0ABCDEF;
    ports[3] = 32'h0FEDCBA;
    push_exp(2, ports[2]);
    push_exp(3, ports[3]);
    wait_busy(t0);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    count_high(l0);
    check("en drop remaining len", 32'(l0), 5);
    wait_drain("en drop drain");
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy) n++;
    end
    check("en hold idle", 32'(n), 0);
    enable = 1'b1;
    @(negedge clk);
    check("en resume", 32'(busy), 1);
    count_high(l0);

    // Reset in the middle of a scan with an event queued.
    evt_ready = 1'b0;
    ports[0] = 32'h0000099;
    wait_busy(t0);
    repeat (2) @(negedge clk);
    check("rst pre valid", 32'(evt_valid), 1);
    reset_n = 1'b0;
    #1;
    check_reset_vals("midscan reset");
    sb.delete();
    evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) push_exp(k, ports[k]);
    @(negedge clk);
    reset_n = 1'b1;
    wait_drain("rst reemit drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
